input_port_unit: RTL and testbench

INPUT_PORT_UNIT -- requirements
Module: input_port_unit

---
 rtl/input_port_unit.sv | 167 ++++++++++++++++
 tb/tb_input_port_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_unit.sv
// Router input port: per-VC flit FIFOs, per-VC IDLE/ROUTING/ACTIVE FSM with XY routing,
// switch-allocation requests and credit return. Optional INPUT_PORT_OVERFLOW_CHECK_EN flag.
module input_port_unit #(
  parameter int unsigned VC_NUM  = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned FLIT_W  = 32,
  parameter int unsigned COORD_W = 2,
  parameter int unsigned CUR_X   = 0,
  parameter int unsigned CUR_Y   = 0,
  localparam int unsigned VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                       clk,
  input  logic                       RSTn,
  input  logic                       flit_in_valid,
  input  logic [VC_W-1:0]            flit_in_vc,
  input  logic [FLIT_W-1:0]          flit_in,
  output logic [VC_NUM-1:0]          vc_request,
  output logic [VC_NUM-1:0][2:0]     vc_target_port,
  input  logic [VC_NUM-1:0]          vc_grant,
  output logic                       flit_out_valid,
  output logic [FLIT_W-1:0]          flit_out,
  output logic [2:0]                 flit_out_port,
  output logic                       credit_out_valid,
  output logic [VC_W-1:0]            credit_out_vc,
  output logic                       overflow_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [2:0] PortLocal = 3'd0;
  localparam logic [2:0] PortEast  = 3'd1;
  localparam logic [2:0] PortWest  = 3'd2;
  localparam logic [2:0] PortNorth = 3'd3;
  localparam logic [2:0] PortSouth = 3'd4;

  typedef enum logic [1:0] {StIdle, StRouting, StActive} vc_state_e;

  vc_state_e         state  [VC_NUM];
  logic [AW:0]       wr_ptr [VC_NUM];
  logic [AW:0]       rd_ptr [VC_NUM];
  logic [FLIT_W-1:0] mem    [VC_NUM][DEPTH];
  logic [FLIT_W-1:0] front  [VC_NUM];

  logic [VC_NUM-1:0] empty, full, wr_en, want_discard, served, discard, pop;
  logic              served_any, discard_any;
  logic [VC_W-1:0]   served_idx, discard_idx;

  function automatic logic [2:0] xy_route(input logic [FLIT_W-1:0] f);
    logic [COORD_W-1:0] dx, dy;
    dx = f[2*COORD_W-1:COORD_W];
    dy = f[COORD_W-1:0];
    if (dx > COORD_W'(CUR_X))      return PortEast;
    else if (dx < COORD_W'(CUR_X)) return PortWest;
    else if (dy > COORD_W'(CUR_Y)) return PortNorth;
    else if (dy < COORD_W'(CUR_Y)) return PortSouth;
    else                           return PortLocal;
  endfunction

  always_comb begin
    empty        = '0;
    full         = '0;
    wr_en        = '0;
    want_discard = '0;
    vc_request   = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      front[v]        = mem[v][rd_ptr[v][AW-1:0]];
      empty[v]        = (wr_ptr[v] == rd_ptr[v]);
      full[v]         = (wr_ptr[v][AW] != rd_ptr[v][AW]) &&
                        (wr_ptr[v][AW-1:0] == rd_ptr[v][AW-1:0]);
      wr_en[v]        = flit_in_valid && (flit_in_vc == VC_W'(v)) && !full[v];
      want_discard[v] = (state[v] == StIdle) && !empty[v] && !front[v][FLIT_W-1];
      vc_request[v]   = (state[v] == StActive) && !empty[v];
    end
  end

  // One credit per cycle: a grant pop wins, otherwise the lowest discarding VC is served.
  always_comb begin
    served      = '0;
    discard     = '0;
    served_any  = 1'b0;
    discard_any = 1'b0;
    served_idx  = '0;
    discard_idx = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (vc_grant[v] && vc_request[v] && !served_any) begin
        served[v]  = 1'b1;
        served_idx = VC_W'(v);
        served_any = 1'b1;
      end
    end
    for (int v = 0; v < VC_NUM; v++) begin
      if (want_discard[v] && !served_any && !discard_any) begin
        discard[v]  = 1'b1;
        discard_idx = VC_W'(v);
        discard_any = 1'b1;
      end
    end
    pop = served | discard;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr[v]         <= '0;
        rd_ptr[v]         <= '0;
        state[v]          <= StIdle;
        vc_target_port[v] <= PortLocal;
      end
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (wr_en[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (pop[v])   rd_ptr[v] <= rd_ptr[v] + 1'b1;
        unique case (state[v])
          StIdle: begin
            if (!empty[v] && front[v][FLIT_W-1]) state[v] <= StRouting;
          end
          StRouting: begin
            vc_target_port[v] <= xy_route(front[v]);
            state[v]          <= StActive;
          end
          StActive: begin
            if (served[v] && front[v][FLIT_W-2]) state[v] <= StIdle;
          end
          default: state[v] <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (wr_en[v]) mem[v][wr_ptr[v][AW-1:0]] <= flit_in;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      flit_out_valid   <= 1'b0;
      flit_out         <= '0;
      flit_out_port    <= PortLocal;
      credit_out_valid <= 1'b0;
      credit_out_vc    <= '0;
    end else if (served_any) begin
      flit_out_valid   <= 1'b1;
      flit_out         <= front[served_idx];
      flit_out_port    <= vc_target_port[served_idx];
      credit_out_valid <= 1'b1;
      credit_out_vc    <= served_idx;
    end else if (discard_any) begin
      flit_out_valid   <= 1'b0;
      credit_out_valid <= 1'b1;
      credit_out_vc    <= discard_idx;
    end else begin
      flit_out_valid   <= 1'b0;
      credit_out_valid <= 1'b0;
    end
  end

`ifdef INPUT_PORT_OVERFLOW_CHECK_EN
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)                                  overflow_err <= 1'b0;
    else if (flit_in_valid && full[flit_in_vc]) overflow_err <= 1'b1;
  end
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_input_port_unit.sv
// Directed self-checking bench for input_port_unit (VC_NUM=2, DEPTH=4, FLIT_W=32, CUR=(0,0)).
module tb_input_port_unit;

  logic             clk = 1'b0;
  logic             RSTn;
  logic             flit_in_valid;
  logic [0:0]       flit_in_vc;
  logic [31:0]      flit_in;
  logic [1:0]       vc_request;
  logic [1:0][2:0]  vc_target_port;
  logic [1:0]       vc_grant;
  logic             flit_out_valid;
  logic [31:0]      flit_out;
  logic [2:0]       flit_out_port;
  logic             credit_out_valid;
  logic [0:0]       credit_out_vc;
  logic             overflow_err;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] f [5];

  localparam logic [2:0] LOCAL = 3'd0;
  localparam logic [2:0] EAST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd3;
`ifdef INPUT_PORT_OVERFLOW_CHECK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  input_port_unit dut (
    .clk(clk), .RSTn(RSTn), .flit_in_valid(flit_in_valid), .flit_in_vc(flit_in_vc),
    .flit_in(flit_in), .vc_request(vc_request), .vc_target_port(vc_target_port),
    .vc_grant(vc_grant), .flit_out_valid(flit_out_valid), .flit_out(flit_out),
    .flit_out_port(flit_out_port), .credit_out_valid(credit_out_valid),
    .credit_out_vc(credit_out_vc), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic h, input logic t, input logic [1:0] dx,
                                     input logic [1:0] dy, input logic [25:0] pl);
    return {h, t, pl, dx, dy};
  endfunction

  task automatic write_flit(input logic vc, input logic [31:0] fl);
    flit_in_valid = 1'b1;
    flit_in_vc    = vc;
    flit_in       = fl;
    tick();
    flit_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0; flit_in_valid = 1'b0; flit_in_vc = '0; flit_in = '0; vc_grant = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (vc_request !== 2'b00) begin n_fail++; $display("FAIL rst_req got %b want 00", vc_request); end
    n_vec++; if (vc_target_port !== 6'd0) begin n_fail++; $display("FAIL rst_port got %h want 0", vc_target_port); end
    n_vec++; if (flit_out_valid !== 1'b0 || flit_out !== 32'd0 || flit_out_port !== LOCAL) begin
      n_fail++; $display("FAIL rst_flit got v=%b d=%h p=%0d want 0/0/0", flit_out_valid, flit_out, flit_out_port); end
    n_vec++; if (credit_out_valid !== 1'b0 || credit_out_vc !== 1'b0) begin
      n_fail++; $display("FAIL rst_credit got v=%b vc=%b want 0/0", credit_out_valid, credit_out_vc); end
    n_vec++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", overflow_err); end
    RSTn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    f[0] = mk(1'b1, 1'b1, 2'd1, 2'd0, 26'h0AA55);
    write_flit(1'b1, f[0]);
    n_vec++; if (vc_request !== 2'b00) begin n_fail++; $display("FAIL single_req_n got %b want 00", vc_request); end
    tick();
    n_vec++; if (vc_request !== 2'b00) begin n_fail++; $display("FAIL single_req_n1 got %b want 00", vc_request); end
    tick();
    n_vec++; if (vc_request !== 2'b10) begin n_fail++; $display("FAIL single_req_n2 got %b want 10", vc_request); end
    n_vec++; if (vc_target_port[1] !== EAST) begin n_fail++; $display("FAIL single_route got %0d want %0d", vc_target_port[1], EAST); end
    vc_grant = 2'b10;
    tick();
    vc_grant = 2'b00;
    n_vec++; if (flit_out_valid !== 1'b1 || flit_out !== f[0] || flit_out_port !== EAST) begin
      n_fail++; $display("FAIL single_out got v=%b d=%h p=%0d want 1/%h/%0d", flit_out_valid, flit_out, flit_out_port, f[0], EAST); end
    n_vec++; if (credit_out_valid !== 1'b1 || credit_out_vc !== 1'b1) begin
      n_fail++; $display("FAIL single_credit got v=%b vc=%b want 1/1", credit_out_valid, credit_out_vc); end
    n_vec++; if (vc_request !== 2'b00) begin n_fail++; $display("FAIL single_idle got %b want 00", vc_request); end
    tick();
    n_vec++; if (flit_out_valid !== 1'b0 || credit_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_pulse got v=%b c=%b want 0/0", flit_out_valid, credit_out_valid); end
  endtask

  task automatic test_discard();
    write_flit(1'b0, mk(1'b0, 1'b0, 2'd2, 2'd1, 26'h1234));
    n_vec++; if (credit_out_valid !== 1'b0) begin n_fail++; $display("FAIL disc_early got %b want 0", credit_out_valid); end
    tick();
    n_vec++; if (credit_out_valid !== 1'b1 || credit_out_vc !== 1'b0 || flit_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL disc_credit got c=%b vc=%b fv=%b want 1/0/0", credit_out_valid, credit_out_vc, flit_out_valid); end
    tick();
    n_vec++; if (credit_out_valid !== 1'b0 || vc_request !== 2'b00) begin
      n_fail++; $display("FAIL disc_after got c=%b req=%b want 0/00", credit_out_valid, vc_request); end
  endtask

  task automatic test_packet();
    f[0] = mk(1'b1, 1'b0, 2'd0, 2'd0, 26'h000111);
    f[1] = mk(1'b0, 1'b0, 2'd3, 2'd3, 26'h000222);
    f[2] = mk(1'b0, 1'b1, 2'd1, 2'd2, 26'h000333);
    for (int i = 0; i < 3; i++) write_flit(1'b0, f[i]);
    n_vec++; if (vc_request !== 2'b01) begin n_fail++; $display("FAIL pkt_req got %b want 01", vc_request); end
    vc_grant = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (flit_out_valid !== 1'b1 || flit_out !== f[i] || flit_out_port !== LOCAL) begin
        n_fail++; $display("FAIL pkt_out%0d got v=%b d=%h p=%0d want 1/%h/0", i, flit_out_valid, flit_out, flit_out_port, f[i]); end
    end
    vc_grant = 2'b00;
    n_vec++; if (vc_request !== 2'b00) begin n_fail++; $display("FAIL pkt_tail_req got %b want 00", vc_request); end
    tick();
    n_vec++; if (flit_out_valid !== 1'b0) begin n_fail++; $display("FAIL pkt_end got %b want 0", flit_out_valid); end
  endtask

  task automatic test_credit_conflict();
    f[0] = mk(1'b1, 1'b0, 2'd0, 2'd1, 26'h0C0);
    f[1] = mk(1'b0, 1'b1, 2'd0, 2'd1, 26'h0C1);
    write_flit(1'b0, f[0]);
    write_flit(1'b0, f[1]);
    tick();
    write_flit(1'b1, mk(1'b0, 1'b1, 2'd0, 2'd0, 26'h0DD));
    vc_grant = 2'b01;
    tick();
    vc_grant = 2'b00;
    n_vec++; if (flit_out_valid !== 1'b1 || flit_out !== f[0] || flit_out_port !== NORTH || credit_out_vc !== 1'b0) begin
      n_fail++; $display("FAIL conf_grant got v=%b d=%h p=%0d cvc=%b want 1/%h/3/0", flit_out_valid, flit_out, flit_out_port, credit_out_vc, f[0]); end
    tick();
    n_vec++; if (credit_out_valid !== 1'b1 || credit_out_vc !== 1'b1 || flit_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL conf_defer got c=%b vc=%b fv=%b want 1/1/0", credit_out_valid, credit_out_vc, flit_out_valid); end
    vc_grant = 2'b01;
    tick();
    vc_grant = 2'b00;
    n_vec++; if (flit_out !== f[1] || credit_out_vc !== 1'b0 || vc_request !== 2'b00) begin
      n_fail++; $display("FAIL conf_tail got d=%h cvc=%b req=%b want %h/0/00", flit_out, credit_out_vc, vc_request, f[1]); end
    tick();
  endtask

  task automatic test_overflow();
    f[0] = mk(1'b1, 1'b0, 2'd2, 2'd0, 26'h0F0);
    f[1] = mk(1'b0, 1'b0, 2'd0, 2'd0, 26'h0F1);
    f[2] = mk(1'b0, 1'b0, 2'd0, 2'd0, 26'h0F2);
    f[3] = mk(1'b0, 1'b1, 2'd0, 2'd0, 26'h0F3);
    f[4] = mk(1'b1, 1'b1, 2'd3, 2'd3, 26'h0F4);
    for (int i = 0; i < 4; i++) write_flit(1'b0, f[i]);
    n_vec++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", overflow_err); end
    write_flit(1'b0, f[4]);
    n_vec++; if (overflow_err !== OVF_EXP) begin n_fail++; $display("FAIL ovf_flag got %b want %b", overflow_err, OVF_EXP); end
    n_vec++; if (vc_request !== 2'b01 || vc_target_port[0] !== EAST) begin
      n_fail++; $display("FAIL ovf_route got req=%b p=%0d want 01/1", vc_request, vc_target_port[0]); end
    vc_grant = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (flit_out_valid !== 1'b1 || flit_out !== f[i]) begin
        n_fail++; $display("FAIL ovf_drain%0d got v=%b d=%h want 1/%h", i, flit_out_valid, flit_out, f[i]); end
    end
    vc_grant = 2'b00;
    n_vec++; if (vc_request !== 2'b00) begin n_fail++; $display("FAIL ovf_dropped got req=%b want 00", vc_request); end
    tick();
    n_vec++; if (overflow_err !== OVF_EXP || flit_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_sticky got ovf=%b fv=%b want %b/0", overflow_err, flit_out_valid, OVF_EXP); end
  endtask

  task automatic test_arbitration();
    f[0] = mk(1'b1, 1'b0, 2'd0, 2'd2, 26'h0A0);
    f[1] = mk(1'b1, 1'b0, 2'd0, 2'd0, 26'h0B0);
    f[2] = mk(1'b0, 1'b1, 2'd0, 2'd2, 26'h0A1);
    f[3] = mk(1'b0, 1'b1, 2'd0, 2'd0, 26'h0B1);
    write_flit(1'b0, f[0]);
    write_flit(1'b1, f[1]);
    write_flit(1'b0, f[2]);
    write_flit(1'b1, f[3]);
    n_vec++; if (vc_request !== 2'b11) begin n_fail++; $display("FAIL arb_both got %b want 11", vc_request); end
    vc_grant = 2'b11;
    tick();
    vc_grant = 2'b00;
    n_vec++; if (flit_out !== f[0] || flit_out_port !== NORTH || credit_out_vc !== 1'b0) begin
      n_fail++; $display("FAIL arb_low got d=%h p=%0d cvc=%b want %h/3/0", flit_out, flit_out_port, credit_out_vc, f[0]); end
    n_vec++; if (vc_request !== 2'b11) begin n_fail++; $display("FAIL arb_keep got %b want 11", vc_request); end
    vc_grant = 2'b01;
    tick();
    n_vec++; if (flit_out !== f[2] || vc_request !== 2'b10) begin
      n_fail++; $display("FAIL arb_vc0_tail got d=%h req=%b want %h/10", flit_out, vc_request, f[2]); end
    vc_grant = 2'b10;
    tick();
    n_vec++; if (flit_out !== f[1] || flit_out_port !== LOCAL || credit_out_vc !== 1'b1) begin
      n_fail++; $display("FAIL arb_vc1_head got d=%h p=%0d cvc=%b want %h/0/1", flit_out, flit_out_port, credit_out_vc, f[1]); end
    tick();
    vc_grant = 2'b00;
    n_vec++; if (flit_out !== f[3] || vc_request !== 2'b00) begin
      n_fail++; $display("FAIL arb_vc1_tail got d=%h req=%b want %h/00", flit_out, vc_request, f[3]); end
    tick();
  endtask

  task automatic test_reset_mid();
    write_flit(1'b1, mk(1'b1, 1'b0, 2'd1, 2'd1, 26'h0E0));
    write_flit(1'b1, mk(1'b0, 1'b0, 2'd1, 2'd1, 26'h0E1));
    tick();
    n_vec++; if (vc_request !== 2'b10 || vc_target_port[1] !== EAST) begin
      n_fail++; $display("FAIL mid_pre got req=%b p=%0d want 10/1", vc_request, vc_target_port[1]); end
    RSTn = 1'b0;
    #1;
    n_vec++; if (vc_request !== 2'b00 || vc_target_port !== 6'd0) begin
      n_fail++; $display("FAIL mid_async got req=%b p=%h want 00/0", vc_request, vc_target_port); end
    tick();
    RSTn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (vc_request !== 2'b00 || credit_out_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_quiet%0d got req=%b c=%b want 00/0", i, vc_request, credit_out_valid); end
    end
    f[0] = mk(1'b1, 1'b1, 2'd1, 2'd0, 26'h0E7);
    write_flit(1'b1, f[0]);
    tick();
    tick();
    n_vec++; if (vc_request !== 2'b10 || vc_target_port[1] !== EAST) begin
      n_fail++; $display("FAIL mid_new got req=%b p=%0d want 10/1", vc_request, vc_target_port[1]); end
    vc_grant = 2'b10;
    tick();
    vc_grant = 2'b00;
    n_vec++; if (flit_out_valid !== 1'b1 || flit_out !== f[0] || credit_out_vc !== 1'b1) begin
      n_fail++; $display("FAIL mid_out got v=%b d=%h cvc=%b want 1/%h/1", flit_out_valid, flit_out, credit_out_vc, f[0]); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_discard();
    test_packet();
    test_credit_conflict();
    test_overflow();
    test_arbitration();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
